// File: rtl/vrf_pkg.sv
// Shared constants and types for the multi-port vector register file.
package vrf_pkg;

    localparam int unsigned DEF_VREG_DW = 256;
    localparam int unsigned DEF_VREG_AW = 5;
    localparam int unsigned VBE_W       = DEF_VREG_DW / 8;

    typedef logic [DEF_VREG_DW-1:0] vreg_t;
    typedef logic [DEF_VREG_AW-1:0] vaddr_t;

endpackage

// File: rtl/v_regfile_mp_if.sv
// Writeback, read and reservation bus of the vector register file.
// The issue/writeback logic is the master and the register file is the slave.
interface v_regfile_mp_if
    import vrf_pkg::*;
#(
    parameter int unsigned VREG_DW = DEF_VREG_DW,
    parameter int unsigned VREG_AW = DEF_VREG_AW,
    parameter int unsigned NUM_WP  = 2,
    parameter int unsigned NUM_RP  = 4,
    parameter int unsigned NUM_RSV = 2
) ();

    logic [NUM_WP-1:0]              wb_en_i;
    logic [NUM_WP*VREG_AW-1:0]      wb_addr_i;
    logic [NUM_WP*VREG_DW-1:0]      wb_data_i;
    logic [NUM_WP*(VREG_DW/8)-1:0]  wb_be_i;
    logic [NUM_RP-1:0]              rd_en_i;
    logic [NUM_RP*VREG_AW-1:0]      rd_addr_i;
    logic [NUM_RP*VREG_DW-1:0]      rd_data_o;
    logic [NUM_RP-1:0]              rd_valid_o;
    logic [NUM_RP-1:0]              rd_hazard_o;
    logic [NUM_RSV-1:0]             rsv_en_i;
    logic [NUM_RSV*VREG_AW-1:0]     rsv_addr_i;
    logic [(2**VREG_AW)-1:0]        busy_o;

    modport master (
        output wb_en_i, wb_addr_i, wb_data_i, wb_be_i,
        output rd_en_i, rd_addr_i,
        output rsv_en_i, rsv_addr_i,
        input  rd_data_o, rd_valid_o, rd_hazard_o, busy_o
    );

    modport slave (
        input  wb_en_i, wb_addr_i, wb_data_i, wb_be_i,
        input  rd_en_i, rd_addr_i,
        input  rsv_en_i, rsv_addr_i,
        output rd_data_o, rd_valid_o, rd_hazard_o, busy_o
    );

endinterface

// File: rtl/vrf_wr_merge.sv
// Next value of one register entry from all write ports: per-byte merge,
// highest port index wins. hit_o flags any enabled write to this entry.
module vrf_wr_merge
    import vrf_pkg::*;
#(
    parameter int unsigned VREG_DW = DEF_VREG_DW,
    parameter int unsigned VREG_AW = DEF_VREG_AW,
    parameter int unsigned NUM_WP  = 2,
    parameter int unsigned ENTRY   = 1
) (
    input  logic [VREG_DW-1:0]             cur_i,
    input  logic [NUM_WP-1:0]              wb_en_i,
    input  logic [NUM_WP*VREG_AW-1:0]      wb_addr_i,
    input  logic [NUM_WP*VREG_DW-1:0]      wb_data_i,
    input  logic [NUM_WP*(VREG_DW/8)-1:0]  wb_be_i,
    output logic [VREG_DW-1:0]             nxt_o,
    output logic                           hit_o
);

    localparam int unsigned BeW = VREG_DW / 8;

    // Ports are applied in ascending order so a later (higher) port overwrites.
    always_comb begin
        nxt_o = cur_i;
        hit_o = 1'b0;
        for (int p = 0; p < NUM_WP; p++) begin
            if (wb_en_i[p] && (wb_addr_i[p*VREG_AW +: VREG_AW] == VREG_AW'(ENTRY))) begin
                hit_o = 1'b1;
                for (int b = 0; b < BeW; b++) begin
                    if (wb_be_i[p*BeW + b]) begin
                        nxt_o[b*8 +: 8] = wb_data_i[p*VREG_DW + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/v_regfile_mp.sv
// Multi-port vector register file with registered reads and busy scoreboard.
// Define VRF_BYPASS_EN to forward same-cycle writes to reads.
module v_regfile_mp
    import vrf_pkg::*;
#(
    parameter int unsigned VREG_DW = DEF_VREG_DW,
    parameter int unsigned VREG_AW = DEF_VREG_AW,
    parameter int unsigned NUM_WP  = 2,
    parameter int unsigned NUM_RP  = 4,
    parameter int unsigned NUM_RSV = 2
) (
    input  logic           clk,
    input  logic           rst,
    v_regfile_mp_if.slave  bus
);

    localparam int unsigned NumRegs = 2 ** VREG_AW;

    logic [VREG_DW-1:0]        mem_q [NumRegs];
    logic [VREG_DW-1:0]        mem_d [NumRegs];
    logic [NumRegs-1:0]        wr_hit;
    logic [NumRegs-1:0]        busy_q, busy_d;
    logic [NUM_RP*VREG_DW-1:0] rd_data_q, rd_data_d;
    logic [NUM_RP-1:0]         rd_valid_q, rd_valid_d;
    logic [NUM_RP-1:0]         rd_hazard_q, rd_hazard_d;

    // Register 0 is hardwired to zero and never written.
    assign mem_d[0]  = '0;
    assign wr_hit[0] = 1'b0;

    for (genvar e = 1; e < NumRegs; e++) begin : g_entry
        vrf_wr_merge #(
            .VREG_DW (VREG_DW),
            .VREG_AW (VREG_AW),
            .NUM_WP  (NUM_WP),
            .ENTRY   (e)
        ) u_merge (
            .cur_i     (mem_q[e]),
            .wb_en_i   (bus.wb_en_i),
            .wb_addr_i (bus.wb_addr_i),
            .wb_data_i (bus.wb_data_i),
            .wb_be_i   (bus.wb_be_i),
            .nxt_o     (mem_d[e]),
            .hit_o     (wr_hit[e])
        );
    end

    // Writeback clears, reservation sets; set is applied last so it wins.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        for (int k = 0; k < NUM_RSV; k++) begin
            if (bus.rsv_en_i[k]) begin
                busy_d[bus.rsv_addr_i[k*VREG_AW +: VREG_AW]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_data_d   = '0;
        rd_valid_d  = bus.rd_en_i;
        rd_hazard_d = '0;
        for (int r = 0; r < NUM_RP; r++) begin
            if (bus.rd_en_i[r]) begin
`ifdef VRF_BYPASS_EN
                rd_data_d[r*VREG_DW +: VREG_DW] = mem_d[bus.rd_addr_i[r*VREG_AW +: VREG_AW]];
`else
                rd_data_d[r*VREG_DW +: VREG_DW] = mem_q[bus.rd_addr_i[r*VREG_AW +: VREG_AW]];
`endif
                rd_hazard_d[r] = busy_d[bus.rd_addr_i[r*VREG_AW +: VREG_AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            busy_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            rd_hazard_q <= '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_hazard_q <= rd_hazard_d;
        end
    end

    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.rd_hazard_o = rd_hazard_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_v_regfile_mp.sv
// Directed bench for v_regfile_mp with a cycle-level reference model.
module tb_v_regfile_mp;
    import vrf_pkg::*;

    localparam int unsigned DW  = 256;
    localparam int unsigned AW  = 5;
    localparam int unsigned WP  = 2;
    localparam int unsigned RP  = 4;
    localparam int unsigned RSV = 2;
    localparam int unsigned NR  = 32;
    localparam int unsigned BW  = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   model_ok = 1'b0;

    always #5 clk = ~clk;

    v_regfile_mp_if #(
        .VREG_DW (DW), .VREG_AW (AW), .NUM_WP (WP), .NUM_RP (RP), .NUM_RSV (RSV)
    ) bus ();

    v_regfile_mp #(
        .VREG_DW (DW), .VREG_AW (AW), .NUM_WP (WP), .NUM_RP (RP), .NUM_RSV (RSV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: register contents, busy bits, expected read outputs.
    vreg_t          m_mem [NR];
    logic [NR-1:0]  m_busy;
    vreg_t          exp_data [RP];
    logic [RP-1:0]  exp_valid;
    logic [RP-1:0]  exp_haz;

    task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", name, idx, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        vreg_t         nm [NR];
        logic [NR-1:0] nb;
        bit            done;
        if (rst) begin
            for (int a = 0; a < NR; a++) m_mem[a] = '0;
            m_busy    = '0;
            exp_valid = '0;
            exp_haz   = '0;
            for (int r = 0; r < RP; r++) exp_data[r] = '0;
        end else begin
            for (int a = 0; a < NR; a++) nm[a] = m_mem[a];
            // Each byte takes the value from the highest-indexed enabled port.
            for (int a = 1; a < NR; a++) begin
                for (int b = 0; b < BW; b++) begin
                    done = 1'b0;
                    for (int p = WP - 1; p >= 0; p--) begin
                        if (!done && bus.wb_en_i[p] && int'(bus.wb_addr_i[p*AW +: AW]) == a
                            && bus.wb_be_i[p*BW + b]) begin
                            nm[a][b*8 +: 8] = bus.wb_data_i[p*DW + b*8 +: 8];
                            done = 1'b1;
                        end
                    end
                end
            end
            nb = m_busy;
            for (int p = 0; p < WP; p++)
                if (bus.wb_en_i[p]) nb[bus.wb_addr_i[p*AW +: AW]] = 1'b0;
            for (int k = 0; k < RSV; k++)
                if (bus.rsv_en_i[k]) nb[bus.rsv_addr_i[k*AW +: AW]] = 1'b1;
            nb[0] = 1'b0;
            for (int r = 0; r < RP; r++) begin
                if (bus.rd_en_i[r]) begin
`ifdef VRF_BYPASS_EN
                    exp_data[r] = nm[bus.rd_addr_i[r*AW +: AW]];
`else
                    exp_data[r] = m_mem[bus.rd_addr_i[r*AW +: AW]];
`endif
                    exp_valid[r] = 1'b1;
                    exp_haz[r]   = nb[bus.rd_addr_i[r*AW +: AW]];
                end else begin
                    exp_data[r]  = '0;
                    exp_valid[r] = 1'b0;
                    exp_haz[r]   = 1'b0;
                end
            end
            for (int a = 0; a < NR; a++) m_mem[a] = nm[a];
            m_busy = nb;
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int r = 0; r < RP; r++) begin
                chk("valid", r, DW'(bus.rd_valid_o[r]), DW'(exp_valid[r]));
                chk("data", r, bus.rd_data_o[r*DW +: DW], exp_data[r]);
                if (exp_valid[r]) chk("hazard", r, DW'(bus.rd_hazard_o[r]), DW'(exp_haz[r]));
            end
            chk("busy", 0, DW'(bus.busy_o), DW'(m_busy));
        end
    end

    task automatic clear_inputs();
        bus.wb_en_i    = '0;
        bus.wb_addr_i  = '0;
        bus.wb_data_i  = '0;
        bus.wb_be_i    = '0;
        bus.rd_en_i    = '0;
        bus.rd_addr_i  = '0;
        bus.rsv_en_i   = '0;
        bus.rsv_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic wr(int p, int a, logic [DW-1:0] d, logic [BW-1:0] be);
        bus.wb_en_i[p]             = 1'b1;
        bus.wb_addr_i[p*AW +: AW]  = AW'(a);
        bus.wb_data_i[p*DW +: DW]  = d;
        bus.wb_be_i[p*BW +: BW]    = be;
    endtask

    task automatic rd(int r, int a);
        bus.rd_en_i[r]            = 1'b1;
        bus.rd_addr_i[r*AW +: AW] = AW'(a);
    endtask

    task automatic rsv(int k, int a);
        bus.rsv_en_i[k]            = 1'b1;
        bus.rsv_addr_i[k*AW +: AW] = AW'(a);
    endtask

    localparam logic [BW-1:0] BeAll = '1;

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst_busy", 0, DW'(bus.busy_o), '0);
        chk("rst_valid", 0, DW'(bus.rd_valid_o), '0);
        rst = 1'b0;

        // Write then read on port 2.
        wr(0, 3, {32{8'hA5}}, BeAll);
        tick();
        rd(2, 3);
        tick();
        chk("wr_rd_valid", 2, DW'(bus.rd_valid_o[2]), DW'(1'b1));
        chk("wr_rd_data", 2, bus.rd_data_o[2*DW +: DW], {32{8'hA5}});

        // Register 0 ignores writes and reservations.
        wr(1, 0, '1, BeAll);
        tick();
        rsv(0, 0);
        rd(0, 0);
        tick();
        chk("r0_data", 0, bus.rd_data_o[0 +: DW], '0);
        chk("r0_busy", 0, DW'(bus.busy_o[0]), '0);

        // Byte-enable collision on v5.
        wr(0, 5, {32{8'h11}}, 32'h0000_FFFF);
        wr(1, 5, {32{8'h22}}, 32'h000F_FF00);
        tick();
        rd(1, 5);
        tick();
        chk("collide", 1, bus.rd_data_o[1*DW +: DW], {96'h0, {12{8'h22}}, {8{8'h11}}});

        // Scoreboard set, hazard, set-beats-clear, clear by write.
        rsv(0, 7);
        tick();
        chk("busy7_set", 7, DW'(bus.busy_o[7]), DW'(1'b1));
        rd(3, 7);
        tick();
        chk("haz7", 3, DW'(bus.rd_hazard_o[3]), DW'(1'b1));
        rsv(1, 7);
        wr(0, 7, {32{8'h5A}}, BeAll);
        tick();
        chk("busy7_keep", 7, DW'(bus.busy_o[7]), DW'(1'b1));
        wr(1, 7, '0, '0);
        tick();
        chk("busy7_clr", 7, DW'(bus.busy_o[7]), '0);
        rsv(0, 8);
        rsv(1, 8);
        tick();
        chk("busy8_dup", 8, DW'(bus.busy_o[8]), DW'(1'b1));
        wr(0, 8, '0, BeAll);
        tick();
        chk("busy8_clr", 8, DW'(bus.busy_o[8]), '0);
        // Hazard sees a reservation made in the same cycle as the read.
        rsv(0, 10);
        rd(1, 10);
        tick();
        chk("haz10_same", 1, DW'(bus.rd_hazard_o[1]), DW'(1'b1));

        // Same-cycle read/write of v9.
        wr(0, 9, {32{8'h33}}, BeAll);
        tick();
        wr(0, 9, {32{8'h44}}, BeAll);
        rd(0, 9);
        tick();
`ifdef VRF_BYPASS_EN
        chk("raw_same", 0, bus.rd_data_o[0 +: DW], {32{8'h44}});
`else
        chk("raw_same", 0, bus.rd_data_o[0 +: DW], {32{8'h33}});
`endif

        // Reset in the middle of back-to-back reads.
        rd(0, 3); rd(1, 5); rd(2, 9); rd(3, 7);
        tick();
        chk("pre_rst_valid", 0, DW'(bus.rd_valid_o), DW'(4'hF));
        rst = 1'b1;
        rd(0, 3); rd(1, 5); rd(2, 9); rd(3, 7);
        wr(0, 11, '1, BeAll);
        rsv(0, 12);
        tick();
        chk("mid_rst_valid", 0, DW'(bus.rd_valid_o), '0);
        chk("mid_rst_data", 2, bus.rd_data_o[2*DW +: DW], '0);
        rst = 1'b0;
        chk("post_rst_busy", 0, DW'(bus.busy_o), '0);
        for (int i = 0; i < NR / RP; i++) begin
            for (int r = 0; r < RP; r++) rd(r, i * RP + r);
            tick();
            for (int r = 0; r < RP; r++)
                chk("post_rst_entry", i * RP + r, bus.rd_data_o[r*DW +: DW], '0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
